// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: glyph codes, segment
// patterns ({a,b,c,d,e,f,g}, seg[6]=a) and the packed records used by the scanner.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [3:0] GLYPH_A     = 4'hA;
    localparam logic [3:0] GLYPH_P     = 4'hB;
    localparam logic [3:0] GLYPH_DASH  = 4'hC;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_P    = 7'h67;
    localparam logic [6:0] SEG_DASH = 7'h01;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Frame-coherent copy of the display inputs.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp_mask;
        logic [NUM_DIGITS-1:0]   blink_mask;
    } snapshot_t;

    // Everything that goes to the pins, registered together.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] en;
        logic [6:0]            seg;
        logic                  dp;
    } drive_t;

    function automatic logic [3:0] glyph_at(input logic [4*NUM_DIGITS-1:0] digits,
                                            input logic [IDX_W-1:0]        idx);
        return digits[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph-code to segment-pattern decoder; codes without a glyph
// (including GLYPH_BLANK) produce a dark digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives seg_o and no latch is inferred.
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:       seg_o = SEG_0;
            4'd1:       seg_o = SEG_1;
            4'd2:       seg_o = SEG_2;
            4'd3:       seg_o = SEG_3;
            4'd4:       seg_o = SEG_4;
            4'd5:       seg_o = SEG_5;
            4'd6:       seg_o = SEG_6;
            4'd7:       seg_o = SEG_7;
            4'd8:       seg_o = SEG_8;
            4'd9:       seg_o = SEG_9;
            GLYPH_A:    seg_o = SEG_A;
            GLYPH_P:    seg_o = SEG_P;
            GLYPH_DASH: seg_o = SEG_DASH;
            default:    seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner with per-slot blanking gap,
// frame-coherent input snapshot and per-digit blinking. All outputs registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dispEn
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [FRM_W-1:0] frm_q,   frm_d;
    logic             phase_q, phase_d;
    snapshot_t        snap_q,  snap_d;
    drive_t           drive_q, drive_d;

    logic       slot_end;
    logic       in_blank;
    logic [6:0] dec_seg;

    assign slot_end = (pre_q == PRE_LAST);
    assign in_blank = (int'(pre_q) < BLANK_CYCLES);

    seg7_decoder u_decoder (
        .code_i (glyph_at(snap_q.digits, idx_q)),
        .seg_o  (dec_seg)
    );

    // Scan counters advance only while enabled; the snapshot is taken on the
    // first cycle of digit 0 so a whole frame always shows one set of inputs.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        snap_d  = snap_q;
        if (en) begin
            if (pre_q == '0 && idx_q == '0) begin
                snap_d.digits     = digits;
                snap_d.dp_mask    = dp_mask;
                snap_d.blink_mask = blink_mask;
            end
            if (slot_end) begin
                pre_d = '0;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    if (frm_q == FRM_LAST) begin
                        frm_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // A blinked digit keeps its enable so slot timing and duty cycle stay fixed.
    always_comb begin
        drive_d = '0;
        if (en && !in_blank) begin
            drive_d.en[idx_q] = 1'b1;
            drive_d.seg       = dec_seg;
            drive_d.dp        = snap_q.dp_mask[idx_q];
            if (phase_q && snap_q.blink_mask[idx_q]) begin
                drive_d.seg = SEG_OFF;
                drive_d.dp  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            drive_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            drive_q <= drive_d;
        end
    end

    assign seg    = drive_q.seg;
    assign dp     = drive_q.dp;
    assign dispEn = drive_q.en;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the stimulus pushes one expected
// {dispEn,seg,dp} per clock edge, a negedge monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int PRESCALE     = 4;
    localparam int BLANK        = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int EN_GAP       = 10;

    localparam logic [31:0] DIGITS_A   = 32'hCBA98765;
    localparam logic [31:0] DIGITS_B   = 32'hFED43210;
    localparam logic [7:0]  BLINK_MASK = 8'h03;

    localparam logic [6:0] SEGS_A [8] = '{7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h67, 7'h01};
    localparam logic [6:0] SEGS_B [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h00, 7'h00, 7'h00};

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef enum {EV_NONE, EV_CHANGE, EV_EN_DROP, EV_RESET} ev_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        en1;
    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic [7:0]  blink_mask;
    logic [6:0]  seg,    seg1;
    logic        dp,     dp1;
    logic [7:0]  dispEn, dispEn1;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   edges1   = 0;

    seg7_scan_driver #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .dispEn     (dispEn)
    );

    // Second instance with no blanking gap: slots must run back-to-back.
    seg7_scan_driver #(
        .PRESCALE     (2),
        .BLANK_CYCLES (0),
        .BLINK_FRAMES (1)
    ) dut_nogap (
        .clk        (clk),
        .reset      (reset),
        .en         (en1),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .seg        (seg1),
        .dp         (dp1),
        .dispEn     (dispEn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("scan[%0d] {dispEn,seg,dp}", n_pop), {dispEn, seg, dp}, e);
            n_pop <= n_pop + 1;
        end
    end

    always @(posedge clk) edges1 <= reset ? edges1 + 1 : 0;

    always @(negedge clk) begin
        if (reset && edges1 > 0)
            check($sformatf("nogap dispEn edge %0d", edges1), {8'h00, dispEn1},
                  {8'h00, 8'(8'h01 << (((edges1 - 1) / 2) % 8))});
    end

    task automatic push(input logic [7:0] en_v, input logic [6:0] s, input logic p);
        exp_t e;
        @(posedge clk);
        #1;
        e.en  = en_v;
        e.seg = s;
        e.dp  = p;
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic push_dark();
        push(8'h00, 7'h00, 1'b0);
    endtask

    task automatic push_lit(input int d, input logic [6:0] s, input logic p);
        push(8'h01 << d, s, p);
    endtask

    task automatic check_dark(input string tag);
        check({tag, " dispEn"}, {8'h00, dispEn}, 16'h0000);
        check({tag, " seg"},    {9'h000, seg},   16'h0000);
        check({tag, " dp"},     {15'h0000, dp},  16'h0000);
    endtask

    // One 8-slot frame of expectations, optionally with an event in one slot.
    task automatic run_frame(input bit set_b, input logic [7:0] dpm, input bit blink,
                             input ev_t ev, input int ev_slot);
        for (int d = 0; d < 8; d++) begin
            logic [6:0] s;
            logic       p;
            s = set_b ? SEGS_B[d] : SEGS_A[d];
            p = dpm[d];
            if (blink && BLINK_MASK[d]) begin
                s = 7'h00;
                p = 1'b0;
            end
            if (ev != EV_NONE && d == ev_slot) begin
                case (ev)
                    EV_CHANGE: begin
                        repeat (BLANK) push_dark();
                        digits  = DIGITS_B;
                        dp_mask = 8'h80;
                        repeat (PRESCALE - BLANK) push_lit(d, s, p);
                    end
                    EV_EN_DROP: begin
                        repeat (BLANK) push_dark();
                        push_lit(d, s, p);
                        en = 1'b0;
                        repeat (EN_GAP) push_dark();
                        en = 1'b1;
                        repeat (PRESCALE - BLANK - 1) push_lit(d, s, p);
                    end
                    EV_RESET: begin
                        repeat (BLANK) push_dark();
                        push_lit(d, s, p);
                        @(negedge clk);
                        #2;
                        reset = 1'b0;
                        #1;
                        check_dark("async reset");
                        return;
                    end
                    default: ;
                endcase
            end else begin
                repeat (BLANK) push_dark();
                repeat (PRESCALE - BLANK) push_lit(d, s, p);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        en         = 1'b1;
        en1        = 1'b1;
        digits     = DIGITS_A;
        dp_mask    = 8'h04;
        blink_mask = BLINK_MASK;
        #2;
        check_dark("reset initial");
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset held");
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_frame(1'b0, 8'h04, 1'b0, EV_NONE,    0);
        run_frame(1'b0, 8'h04, 1'b0, EV_CHANGE,  3);
        run_frame(1'b1, 8'h80, 1'b1, EV_NONE,    0);
        run_frame(1'b1, 8'h80, 1'b1, EV_NONE,    0);
        run_frame(1'b1, 8'h80, 1'b0, EV_EN_DROP, 2);
        run_frame(1'b1, 8'h80, 1'b0, EV_NONE,    0);
        run_frame(1'b1, 8'h80, 1'b1, EV_RESET,   5);

        repeat (2) @(posedge clk);
        #1;
        check_dark("reset held mid-run");
        reset = 1'b1;

        run_frame(1'b1, 8'h80, 1'b0, EV_NONE, 0);
        run_frame(1'b1, 8'h80, 1'b0, EV_NONE, 0);
        run_frame(1'b1, 8'h80, 1'b1, EV_NONE, 0);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard drained", 16'(sb_q.size()), 16'h0000);
        check("pops vs pushes", 16'(n_pop), 16'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
